// File: rtl/bin_morph3x3_pkg.sv
// Shared constants, types and helpers for the binary 3x3 morphology filter.
// Optional frame foreground counter is enabled with MORPH_FGCOUNT_EN.
package bin_morph3x3_pkg;

    localparam int MODE_ERODE  = 0;
    localparam int MODE_DILATE = 1;

    localparam int PIX_W = 12;
    localparam logic [PIX_W-1:0] PIX_FG = 12'd4095;
    localparam logic [PIX_W-1:0] PIX_BG = 12'd0;

    localparam int FGCOUNT_W = 20;

    // Pixel state carried from acceptance to window evaluation.
    typedef struct packed {
        logic valid;
        logic pix;
        logic border;
    } stage1_t;

    function automatic logic win_reduce(input logic [8:0] win, input logic dilate);
        return dilate ? (|win) : (&win);
    endfunction

endpackage

// File: rtl/bin_morph3x3_if.sv
// Pixel stream bundle between the threshold stage, the filter and the capture path.
// The source drives through master; the filter consumes through slave.
interface bin_morph3x3_if
    import bin_morph3x3_pkg::*;
;
    logic                 iFVAL;
    logic                 iDVAL;
    logic [PIX_W-1:0]     iDATA;
    logic                 oDVAL;
    logic [PIX_W-1:0]     oDATA;
    logic [FGCOUNT_W-1:0] oFG_COUNT;
    logic                 oFG_VALID;

    modport master (
        output iFVAL, iDVAL, iDATA,
        input  oDVAL, oDATA, oFG_COUNT, oFG_VALID
    );

    modport slave (
        input  iFVAL, iDVAL, iDATA,
        output oDVAL, oDATA, oFG_COUNT, oFG_VALID
    );

endinterface

// File: rtl/line_buffer_1b.sv
// One-line 1-bit RAM: registered read, single write port, old data on collision.
module line_buffer_1b #(
    parameter int DEPTH = 640,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic          wdata_i,
    output logic          rdata_o
);

    logic mem_q [DEPTH];
    logic rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bin_morph3x3.sv
// Binary 3x3 erode/dilate with two 1-bit line buffers and 2-cycle latency.
// Define MORPH_FGCOUNT_EN to add the per-frame foreground pixel counter.
module bin_morph3x3
    import bin_morph3x3_pkg::*;
#(
    parameter int LINE_WIDTH = 640,
    parameter int MODE       = MODE_ERODE
) (
    input  logic          iCLK,
    input  logic          iRST,
    bin_morph3x3_if.slave bus
);

    localparam int               COL_W     = $clog2(LINE_WIDTH);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(LINE_WIDTH - 1);
    localparam logic             IS_DILATE = (MODE == MODE_DILATE);

    logic             accept;
    logic             pix_in;
    logic [COL_W-1:0] col_q, col_d;
    logic [1:0]       row_q, row_d;
    stage1_t          s1_q, s1_d;
    logic [COL_W-1:0] s1_col_q;

    logic             lb_we    [2];
    logic [COL_W-1:0] lb_waddr [2];
    logic             lb_wdata [2];
    logic             lb_rdata [2];

    logic [1:0][2:0]  win_q, win_d;
    logic [2:0]       new_col;
    logic [8:0]       win_all;

    logic             out_dval_q;
    logic [PIX_W-1:0] out_data_q, out_data_d;

    assign accept = bus.iFVAL & bus.iDVAL;
    assign pix_in = |bus.iDATA;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (!bus.iFVAL) begin
            col_d = '0;
            row_d = '0;
        end else if (accept) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == 2'd2) ? 2'd2 : row_q + 2'd1;
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // Border pixels would otherwise see the previous line through the wrap.
    always_comb begin
        s1_d.valid  = accept;
        s1_d.pix    = pix_in;
        s1_d.border = (row_q < 2'd2) || (col_q < COL_W'(2));
    end

    // Index 1 is the previous line; index 0 receives what line 1 held, one cycle late.
    assign lb_we[1]    = accept;
    assign lb_waddr[1] = col_q;
    assign lb_wdata[1] = pix_in;
    assign lb_we[0]    = s1_q.valid;
    assign lb_waddr[0] = s1_col_q;
    assign lb_wdata[0] = lb_rdata[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lb
            line_buffer_1b #(
                .DEPTH (LINE_WIDTH),
                .AW    (COL_W)
            ) u_lb (
                .clk     (iCLK),
                .re_i    (accept),
                .raddr_i (col_q),
                .we_i    (lb_we[gi]),
                .waddr_i (lb_waddr[gi]),
                .wdata_i (lb_wdata[gi]),
                .rdata_o (lb_rdata[gi])
            );
        end
    endgenerate

    assign new_col = {lb_rdata[0], lb_rdata[1], s1_q.pix};
    assign win_all = {win_q[1], win_q[0], new_col};

    always_comb begin
        win_d = win_q;
        if (!bus.iFVAL) begin
            win_d = '0;
        end else if (s1_q.valid) begin
            win_d = {win_q[0], new_col};
        end
        out_data_d = (s1_q.valid && !s1_q.border && win_reduce(win_all, IS_DILATE))
                     ? PIX_FG : PIX_BG;
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            col_q      <= '0;
            row_q      <= '0;
            s1_q       <= '0;
            s1_col_q   <= '0;
            win_q      <= '0;
            out_dval_q <= 1'b0;
            out_data_q <= PIX_BG;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            s1_q       <= s1_d;
            s1_col_q   <= col_q;
            win_q      <= win_d;
            out_dval_q <= s1_q.valid;
            out_data_q <= out_data_d;
        end
    end

    assign bus.oDVAL = out_dval_q;
    assign bus.oDATA = out_data_q;

`ifdef MORPH_FGCOUNT_EN
    logic [FGCOUNT_W-1:0] fg_cnt_q, fg_cnt_d;
    logic [FGCOUNT_W-1:0] fg_out_q;
    logic                 fg_valid_q;
    logic [1:0]           fval_hist_q;
    logic                 frame_done;

    // High in the cycle carrying the frame's final output (iFVAL fell two cycles ago).
    assign frame_done = fval_hist_q[1] & ~fval_hist_q[0];

    always_comb begin
        fg_cnt_d = fg_cnt_q;
        if (out_dval_q && (out_data_q == PIX_FG) && (fg_cnt_q != {FGCOUNT_W{1'b1}})) begin
            fg_cnt_d = fg_cnt_q + FGCOUNT_W'(1);
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            fg_cnt_q    <= '0;
            fg_out_q    <= '0;
            fg_valid_q  <= 1'b0;
            fval_hist_q <= '0;
        end else begin
            fval_hist_q <= {fval_hist_q[0], bus.iFVAL};
            fg_valid_q  <= frame_done;
            if (frame_done) begin
                fg_out_q <= fg_cnt_d;
                fg_cnt_q <= '0;
            end else begin
                fg_cnt_q <= fg_cnt_d;
            end
        end
    end

    assign bus.oFG_COUNT = fg_out_q;
    assign bus.oFG_VALID = fg_valid_q;
`else
    assign bus.oFG_COUNT = '0;
    assign bus.oFG_VALID = 1'b0;
`endif

endmodule

// File: tb/tb_bin_morph3x3.sv
// Directed bench: one erode and one dilate instance share an 8-pixel-wide stream.
module tb_bin_morph3x3;
    import bin_morph3x3_pkg::*;

    localparam int W = 8;
    localparam int H = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    bin_morph3x3_if bif0 ();
    bin_morph3x3_if bif1 ();

    bin_morph3x3 #(.LINE_WIDTH(W), .MODE(MODE_ERODE)) u_erode (
        .iCLK (clk),
        .iRST (rst_n),
        .bus  (bif0.slave)
    );

    bin_morph3x3 #(.LINE_WIDTH(W), .MODE(MODE_DILATE)) u_dilate (
        .iCLK (clk),
        .iRST (rst_n),
        .bus  (bif1.slave)
    );

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic        prev_acc     = 1'b0;
    logic [11:0] q0[$];
    logic [11:0] q1[$];
    int          fgp0 = 0, fgp1 = 0;
    logic [19:0] fgv0 = '0, fgv1 = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pattern 0: all foreground. Pattern 1: single foreground pixel at (2,3).
    function automatic logic pix_at(input int pat, input int r, input int c);
        if (pat == 0) return 1'b1;
        return (r == 2) && (c == 3);
    endfunction

    function automatic logic exp_erode(input int pat, input int r, input int c);
        if (pat == 0) return (r >= 2) && (c >= 2);
        return 1'b0;
    endfunction

    function automatic logic exp_dilate(input int pat, input int r, input int c);
        if (pat == 0) return (r >= 2) && (c >= 2);
        return (r >= 2) && (r <= 3) && (c >= 3) && (c <= 5);
    endfunction

    task automatic set_inputs(input logic f, input logic d, input logic [11:0] x);
        bif0.iFVAL = f; bif0.iDVAL = d; bif0.iDATA = x;
        bif1.iFVAL = f; bif1.iDVAL = d; bif1.iDATA = x;
    endtask

    // One clock: oDVAL must reflect the acceptance two cycles earlier.
    task automatic drive(input logic f, input logic d, input logic [11:0] x);
        set_inputs(f, d, x);
        @(posedge clk);
        #1;
        check("odval_erode", bif0.oDVAL, prev_acc);
        check("odval_dilate", bif1.oDVAL, prev_acc);
        prev_acc = f & d;
        if (bif0.oDVAL) q0.push_back(bif0.oDATA);
        if (bif1.oDVAL) q1.push_back(bif1.oDATA);
        if (bif0.oFG_VALID) begin fgp0++; fgv0 = bif0.oFG_COUNT; end
        if (bif1.oFG_VALID) begin fgp1++; fgv1 = bif1.oFG_COUNT; end
    endtask

    task automatic feed(input int pat, input logic gaps, input int npix);
        for (int i = 0; i < npix; i++) begin
            if (gaps) drive(1'b1, 1'b0, 12'd0);
            drive(1'b1, 1'b1, pix_at(pat, i / W, i % W) ? 12'd4095 : 12'd0);
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 12'd0);
    endtask

    task automatic clear_capture();
        q0.delete();
        q1.delete();
        fgp0 = 0; fgp1 = 0;
        fgv0 = '0; fgv1 = '0;
    endtask

    task automatic verify(input string name, input int pat, input int npix,
                          input int fg_e, input int fg_d);
        check({name, "_count_erode"}, q0.size(), npix);
        check({name, "_count_dilate"}, q1.size(), npix);
        for (int i = 0; i < npix && i < q0.size(); i++)
            check($sformatf("%s_erode[%0d]", name, i), q0[i],
                  exp_erode(pat, i / W, i % W) ? 32'd4095 : 32'd0);
        for (int i = 0; i < npix && i < q1.size(); i++)
            check($sformatf("%s_dilate[%0d]", name, i), q1[i],
                  exp_dilate(pat, i / W, i % W) ? 32'd4095 : 32'd0);
`ifdef MORPH_FGCOUNT_EN
        check({name, "_fgpulse_erode"}, fgp0, 1);
        check({name, "_fgcount_erode"}, fgv0, fg_e);
        check({name, "_fgpulse_dilate"}, fgp1, 1);
        check({name, "_fgcount_dilate"}, fgv1, fg_d);
`else
        check({name, "_fgpulse_erode"}, fgp0, 0);
        check({name, "_fgpulse_dilate"}, fgp1, 0);
        check({name, "_fgcount_erode"}, bif0.oFG_COUNT, 0);
        check({name, "_fgcount_dilate"}, bif1.oFG_COUNT, 0 * (fg_e + fg_d));
`endif
        clear_capture();
    endtask

    initial begin
        set_inputs(1'b0, 1'b0, 12'd0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_odval_erode", bif0.oDVAL, 0);
        check("rst_odata_erode", bif0.oDATA, 0);
        check("rst_odval_dilate", bif1.oDVAL, 0);
        check("rst_odata_dilate", bif1.oDATA, 0);
        check("rst_fgcount", bif0.oFG_COUNT, 0);
        check("rst_fgvalid", bif0.oFG_VALID, 0);
        rst_n = 1'b1;
        drain(2);
        clear_capture();

        // All-foreground frame.
        feed(0, 1'b0, W * H);
        drain(4);
        verify("ones", 0, W * H, 12, 12);

        // Single dot: erode removes it, dilate grows it to 2x3.
        feed(1, 1'b0, W * H);
        drain(4);
        verify("dot", 1, W * H, 0, 6);

        // Same frame with a gap cycle before every pixel.
        feed(0, 1'b1, W * H);
        drain(4);
        verify("gaps", 0, W * H, 12, 12);

        // Reset in the middle of line 2 while output is foreground.
        feed(0, 1'b0, 2 * W + 5);
        check("pre_rst_odata_erode", bif0.oDATA, 4095);
        set_inputs(1'b0, 1'b0, 12'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_odval_erode", bif0.oDVAL, 0);
        check("midrst_odata_erode", bif0.oDATA, 0);
        check("midrst_odval_dilate", bif1.oDVAL, 0);
        check("midrst_odata_dilate", bif1.oDATA, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        prev_acc = 1'b0;
        clear_capture();
        drain(3);
        check("postrst_no_output", q0.size() + q1.size(), 0);
        feed(0, 1'b0, W * H);
        drain(4);
        verify("after_rst", 0, W * H, 12, 12);

        // Frame valid drops at col 5 of row 2; in-flight pixels still emerge.
        feed(0, 1'b0, 2 * W + 5);
        drain(4);
        verify("fval_drop", 0, 2 * W + 5, 3, 3);
        feed(0, 1'b0, W * H);
        drain(4);
        verify("next_frame", 0, W * H, 12, 12);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bin_morph3x3.md
# bin_morph3x3

Binary 3x3 morphological filter (erode or dilate) placed directly after the gray-to-binary threshold stage. It consumes the 12-bit binary pixel stream (0 or 4095) and removes isolated speckle (erode) or fills pinholes (dilate) using two 1-bit line buffers. It emits a cleaned 12-bit binary stream, one output per input, for the capture/display path.

## Interface
- LINE_WIDTH, 640: active pixels per line; 3 ≤ LINE_WIDTH ≤ 4096.
- MODE, 0: 0 = erode (AND of window), 1 = dilate (OR of window).
- iCLK  in  1  pixel clock; all logic on rising edge.
- iRST  in  1  asynchronous, active-low reset.
- iFVAL  in  1  frame valid; low between frames.
- iDVAL  in  1  input pixel valid.
- iDATA  in  12  binary pixel; foreground when iDATA != 0.
- oDVAL  out  1  output pixel valid.
- oDATA  out  12  4095 = foreground, 0 = background.
- oFG_COUNT  out  20  foreground output pixels in last frame (only with MORPH_FGCOUNT_EN).
- oFG_VALID  out  1  one-cycle pulse when oFG_COUNT updates (only with MORPH_FGCOUNT_EN).

## Operation
- Input bit b = (iDATA != 0). Pixels accepted only on cycles with iFVAL=1 and iDVAL=1.
- Column counter col: 0..LINE_WIDTH-1, +1 per accepted pixel, wraps to 0. On wrap, row counter row increments, saturating at 2.
- iFVAL=0: col, row, and the 3x3 window registers clear to 0. Line buffer contents are kept, but are masked by the row check below.
- Line buffers: LB1 holds the previous line and LB0 the line before it, both indexed by col. Each accepted pixel reads both at col, writes b into LB1[col], and writes the old LB1[col] into LB0[col].
- Window: when the pixel at (row, col) is accepted, a 3-column shift register takes {LB0[col], LB1[col], b}. The window covers rows r-2..r and columns c-2..c, with its centre at (r-1, c-1).
- Result: MODE 0 outputs the AND of 9 bits; MODE 1 outputs the OR of 9 bits.
- Border: if row < 2 or col < 2 at acceptance, output is background in both modes. This prevents wrap into the previous line.
- The output image is therefore the filtered image shifted down and right by one pixel, with a 2-pixel zero border at top and left.
- Gaps in iDVAL inside a line are legal. The window and counters hold during gaps.
- Reset: oDVAL=0, oDATA=0, oFG_COUNT=0, oFG_VALID=0. Counters, window and pipeline clear. Line buffers are not cleared.

## Timing
- Latency is 2 cycles. An input accepted at cycle N produces oDVAL=1 at N+2 with its result.
  - Cycle N+1: line buffer read data returns.
  - Cycle N+2: window evaluation is registered.
- oDVAL = (iDVAL & iFVAL) delayed 2 cycles. Output count always equals accepted input count.
- Read-during-write at the same address returns old data.
- If iFVAL falls, the pixels already in the 2-stage pipeline still emerge on the following cycles.
- A pixel accepted in the same cycle iFVAL returns high has col=0, row=0.
- Reset asserted mid-frame flushes the pipeline immediately; no pending outputs emerge.

## Configuration
- MORPH_FGCOUNT_EN defined:
  - A 20-bit counter increments on each oDVAL=1 with oDATA=4095, saturating at 2^20-1.
  - On the first cycle after the last output of a frame (iFVAL falling plus 2 cycles), the count is copied to oFG_COUNT, oFG_VALID pulses for 1 cycle, and the counter clears.
- MORPH_FGCOUNT_EN undefined: the counter is absent, and oFG_COUNT and oFG_VALID are tied to 0.

## Structure
- Shared package holds:
  - MODE_ERODE=0 and MODE_DILATE=1.
  - Pixel constants PIX_FG=12'd4095 and PIX_BG=12'd0.
  - FGCOUNT_W=20.
- Sub-module line_buffer_1b: LINE_WIDTH x 1-bit synchronous RAM, one read and one write port, old-data-on-collision. Instantiated twice (LB0, LB1).
- The top level contains the counters, window shift register, reduction, and the optional frame counter.

## Test plan
- LINE_WIDTH=8, MODE=0, 4-line all-4095 frame → outputs 1 through 16 are 0. In rows 2 and 3, cols 0–1 are 0 and cols 2–7 are 4095.
- LINE_WIDTH=8, single 4095 at (2,3) in a zero frame → MODE=0: every output is 0. MODE=1: 4095 at output positions rows 2..3 and cols 3..5 only; all others 0.
- Same all-ones frame with iDVAL low every other cycle → identical output sequence. oDVAL spacing mirrors the input, delayed 2 cycles.
- iRST pulsed low mid-line 2 → oDVAL and oDATA go to 0 immediately. The next frame output matches a clean first frame.
- iFVAL dropped at col 5 of row 2, then a new frame starts → the 2 in-flight outputs emerge. The new frame's first 2 lines output 0.
- MORPH_FGCOUNT_EN, MODE=0, first test frame → oFG_VALID pulses once after the frame with oFG_COUNT=12. It does not pulse during the frame.
